alu_issue_wb: RTL
=================

ALU_ISSUE_WB -- requirements
Module: alu_issue_wb

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 in_valid  input  1  instruction offered this cycle.
REQ-004 in_ready  output  1  block can accept an instruction; an instruction is accepted when in_valid && in_ready at a rising edge.
REQ-005 in_ctrl  input  4  ALU opcode, passed to the downstream 8-bit ALU unchanged; 4'b1101 means LOADI.
REQ-006 in_rs1 / in_rs2 / in_rd  input  3 each  source-x, source-y and destination register index.
REQ-007 in_imm  input  8  immediate, used only by LOADI.
REQ-008 alu_ctrl  output  4  opcode to the ALU, from the EX register.
REQ-009 alu_x / alu_y  output  8 each  operands to the ALU, from the EX register.
REQ-010 alu_out  input  8  combinational ALU result for alu_ctrl/alu_x/alu_y.
REQ-011 alu_carry  input  1  combinational ALU carry.
REQ-012 wb_valid  output  1  one-cycle pulse: a writeback completed at the previous edge.
REQ-013 wb_rd / wb_data  output  3 / 8  index and data of that writeback.
REQ-014 flag_c  output  1  architectural carry flag.
REQ-015 dbg_addr / dbg_data  input 3 / output 8  combinational debug read port of the register file.

Function
REQ-016 Register file: 8 x 8 bits; R0 SHALL read 0x00, and writes to R0 SHALL be discarded, with wb_valid still pulsing.
REQ-017 in_ready SHALL be 1 whenever rst_n is high (no back-pressure), and 0 while rst_n is low.
REQ-018 Pipeline: instruction accepted at edge N is held in the EX register during cycle N+1 and drives alu_*; at edge N+1, the result is written to the register file; wb_valid/wb_rd/wb_data are visible in cycle N+2.
REQ-019 EX register contents: ctrl, rd, x and y, where x = RF[rs1] and y = RF[rs2].
REQ-020 For LOADI, the EX register SHALL hold x = 0x00 and y = in_imm.
REQ-021 Writeback data SHALL be alu_out for ctrl != 4'b1101, and alu_y for LOADI.
REQ-022 Forwarding: when the EX stage is valid and its rd == rs1 or rs2 (rd != 0) of the instruction being accepted, the operand SHALL take the EX writeback value (alu_out, or alu_y for LOADI) instead of the stale RF value.
REQ-023 Back-to-back dependent instructions SHALL never stall and SHALL never see stale data.
REQ-024 A write and a read of the same register at the same edge SHALL return the new value.
REQ-025 flag_c SHALL update to alu_carry at writeback only for ctrl 4'b0000 (ADD) and 4'b0001 (SUB); all other ops SHALL hold it.
REQ-026 Opcodes 4'b1110 and 4'b1111 SHALL write alu_out (0x00 from the ALU) like any ALU op.
REQ-027 EX-valid flag: set on accept, cleared on a cycle with no accept; while EX is invalid, no RF write, no wb_valid and no flag update occur.
REQ-028 EX-invalid outputs: alu_ctrl/alu_x/alu_y SHALL hold their last values (don't-care to the ALU).
REQ-029 Widths: all data is 8 bits and no sign handling is done in this block; carry semantics come from the ALU.

Reset
REQ-030 While rst_n is low at an edge: all RF entries, EX register, alu_ctrl, alu_x, alu_y, wb_rd, wb_data and flag_c SHALL be cleared to 0, and EX-valid and wb_valid SHALL be cleared.
REQ-031 An instruction in EX when reset is sampled SHALL be discarded without writeback.
REQ-032 An instruction presented during reset SHALL not be accepted.
REQ-033 The first accept is possible at the first edge with rst_n high.

Verification
REQ-034 LOADI R1=0x05, then LOADI R2=0x03, then ADD R3=R1+R2, back-to-back -> wb_data 0x05, 0x03, 0x08 on consecutive cycles; flag_c=0; dbg R3=0x08.
REQ-035 ADD R4=R3+R3 issued the cycle after ADD R3 (forwarding) -> wb_data 0x10; SUB R5=R2-R1 -> wb_data 0xFE, flag_c=1.
REQ-036 AND R6=R1&R2 after the SUB -> wb_data 0x01, flag_c stays 1; LOADI R0=0xAA -> wb_valid=1, dbg R0=0x00; a following ADD R7=R0+R1 -> 0x05.
REQ-037 in_valid low for 3 cycles between instructions -> no wb_valid pulses and no RF or flag change during the gap.
REQ-038 rst_n low for one edge while ADD is in EX -> no writeback for that ADD; all registers 0x00, flag_c=0; in_ready=0 during reset and 1 after.

Source files
------------

// File: rtl/alu_issue_wb.sv
// Single-issue front end for an external 8-bit ALU: operand fetch with EX-stage
// forwarding, a one-deep EX register, and register-file writeback.

module alu_issue_wb_rf_ent #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module alu_issue_wb #(
  parameter int W    = 8,
  parameter int NREG = 8,
  parameter int RW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_ctrl,
  input  logic [RW-1:0] in_rs1,
  input  logic [RW-1:0] in_rs2,
  input  logic [RW-1:0] in_rd,
  input  logic [W-1:0]  in_imm,
  output logic [3:0]    alu_ctrl,
  output logic [W-1:0]  alu_x,
  output logic [W-1:0]  alu_y,
  input  logic [W-1:0]  alu_out,
  input  logic          alu_carry,
  output logic          wb_valid,
  output logic [RW-1:0] wb_rd,
  output logic [W-1:0]  wb_data,
  output logic          flag_c,
  input  logic [RW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_LOADI = 4'b1101;
  localparam int         STAGES   = 1;

  typedef struct packed {
    logic [3:0]    ctrl;
    logic [RW-1:0] rd;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
  } ex_t;

  ex_t                    ex_q, ex_d;
  logic [STAGES:0]        vld_pipe;  // [0] EX holds a live op, [1] writeback pulse
  logic [NREG-1:0][W-1:0] rf;
  logic                   acc, wr;
  logic [W-1:0]           ex_res, rs1_val, rs2_val;

  assign in_ready = rst_n;
  assign acc      = in_valid & rst_n;
  assign wr       = vld_pipe[0];
  assign ex_res   = (ex_q.ctrl == OP_LOADI) ? ex_q.y : alu_out;

  // R0 is hardwired; the other entries only ever take the EX result.
  for (genvar i = 0; i < NREG; i++) begin : g_rf
    if (i == 0) begin : g_zero
      assign rf[i] = '0;
    end else begin : g_ent
      alu_issue_wb_rf_ent #(.W(W)) u_ent (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr && (ex_q.rd == RW'(i))),
        .d     (ex_res),
        .q     (rf[i])
      );
    end
  end

  // Forward the EX result so a dependent op issued next cycle never sees the
  // pre-write RF value; this also covers same-edge write/read.
  always_comb begin
    rs1_val = rf[in_rs1];
    rs2_val = rf[in_rs2];
    if (wr && (ex_q.rd != '0)) begin
      if (ex_q.rd == in_rs1) rs1_val = ex_res;
      if (ex_q.rd == in_rs2) rs2_val = ex_res;
    end
    ex_d.ctrl = in_ctrl;
    ex_d.rd   = in_rd;
    ex_d.x    = (in_ctrl == OP_LOADI) ? '0     : rs1_val;
    ex_d.y    = (in_ctrl == OP_LOADI) ? in_imm : rs2_val;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q     <= '0;
      vld_pipe <= '0;
      wb_rd    <= '0;
      wb_data  <= '0;
      flag_c   <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], acc};
      if (acc) ex_q <= ex_d;
      if (wr) begin
        wb_rd   <= ex_q.rd;
        wb_data <= ex_res;
        if ((ex_q.ctrl == OP_ADD) || (ex_q.ctrl == OP_SUB)) flag_c <= alu_carry;
      end
    end
  end

  assign wb_valid = vld_pipe[STAGES];
  assign alu_ctrl = ex_q.ctrl;
  assign alu_x    = ex_q.x;
  assign alu_y    = ex_q.y;
  assign dbg_data = rf[dbg_addr];

endmodule
